w_seq_driver: RTL and testbench

Serial stimulus transmitter for the `w`/`z` sequence-detector interface. It accepts a parallel pattern with a length and shifts it out LSB-first, one bit per clock, on `w`/`w_valid`. It also runs a cycle-aligned mirror of the six-state detector so it can predict the detector's `z` (`z_exp`) and count hits. It sits in front of a detector instance in test harnesses and in self-check paths.

---
 rtl/w_seq_driver_pkg.sv | 34 +++
 rtl/w_seq_driver_if.sv | 24 ++
 rtl/w_seq_driver_model.sv | 47 ++++
 rtl/w_seq_driver.sv | 72 +++++++
 tb/tb_w_seq_driver.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/w_seq_driver_pkg.sv
// Shared types for the w/z sequence driver: detector and driver state encodings,
// the detector transition function and the hit-counter ceiling.
package w_seq_pkg;

    typedef enum logic [2:0] {
        DET_A = 3'd0,
        DET_B = 3'd1,
        DET_C = 3'd2,
        DET_D = 3'd3,
        DET_E = 3'd4,
        DET_F = 3'd5
    } det_state_t;

    typedef enum logic [1:0] {
        DRV_IDLE  = 2'd0,
        DRV_SHIFT = 2'd1,
        DRV_DONE  = 2'd2
    } drv_state_t;

    localparam int HIT_MAX = 255;

    function automatic det_state_t det_next(det_state_t s, logic w);
        case (s)
            DET_A:   return w ? DET_B : DET_A;
            DET_B:   return w ? DET_C : DET_D;
            DET_C:   return w ? DET_E : DET_D;
            DET_D:   return w ? DET_F : DET_A;
            DET_E:   return w ? DET_E : DET_D;
            DET_F:   return w ? DET_C : DET_D;
            default: return DET_A;
        endcase
    endfunction

endpackage

// File: rtl/w_seq_driver_if.sv
// Request/stream bundle between a pattern source (master) and the w_seq_driver (slave).
interface w_seq_driver_if #(parameter int MAX_LEN = 16);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               start;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] pattern;
    logic               busy;
    logic               w;
    logic               w_valid;
    logic               done;
    logic               z_exp;
    logic [7:0]         hit_cnt;

    modport master (
        output start, len, pattern,
        input  busy, w, w_valid, done, z_exp, hit_cnt
    );

    modport slave (
        input  start, len, pattern,
        output busy, w, w_valid, done, z_exp, hit_cnt
    );
endinterface

// File: rtl/w_seq_driver_model.sv
// Cycle-aligned mirror of the six-state w/z detector plus a saturating hit counter.
// Only compiled when W_SEQ_DRV_PREDICT_EN is defined.
//  state | meaning
//  A     | reset / nothing useful seen
//  B     | one 1 seen
//  C     | two 1s seen
//  D     | a 0 after progress
//  E     | run of 1s detected (z=1)
//  F     | 1 after D detected (z=1)
`ifdef W_SEQ_DRV_PREDICT_EN
module w_seq_model
    import w_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_w,
    input  logic       i_w_valid,
    input  logic       i_clear,
    output logic       o_z_exp,
    output logic [7:0] o_hit_cnt
);
    det_state_t r_det;
    det_state_t w_det_next;
    logic [7:0] r_hit;
    logic       w_hit;

    assign w_det_next = det_next(r_det, i_w);
    assign w_hit      = i_w_valid && ((w_det_next == DET_E) || (w_det_next == DET_F));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_det <= DET_A;
            r_hit <= '0;
        end else begin
            if (i_w_valid)
                r_det <= w_det_next;
            if (i_clear)
                r_hit <= '0;
            else if (w_hit && (r_hit != 8'(HIT_MAX)))
                r_hit <= r_hit + 8'd1;
        end
    end

    assign o_z_exp   = (r_det == DET_E) || (r_det == DET_F);
    assign o_hit_cnt = r_hit;
endmodule
`endif

// File: rtl/w_seq_driver.sv
// Serial LSB-first pattern transmitter for the w/z detector; with W_SEQ_DRV_PREDICT_EN
// it also carries a detector mirror producing z_exp and hit_cnt.
//  state | meaning
//  IDLE  | waiting for start
//  SHIFT | one pattern bit on w per cycle
//  DONE  | one-cycle done pulse; start accepted as in IDLE
module w_seq_driver
    import w_seq_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input logic           clk,
    input logic           reset_n,
    w_seq_driver_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [1:0] S_IDLE  = 2'(DRV_IDLE);
    localparam logic [1:0] S_SHIFT = 2'(DRV_SHIFT);
    localparam logic [1:0] S_DONE  = 2'(DRV_DONE);

    logic [1:0]         r_state;
    logic [MAX_LEN-1:0] r_shreg;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic               w_accept;
    logic [LEN_W-1:0]   w_len_clamped;

    assign w_accept      = bus.start && (r_state != S_SHIFT);
    assign w_len_clamped = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_shreg <= r_shreg >> 1;
            r_cnt   <= r_cnt + LEN_W'(1);
            if (r_cnt == r_len - LEN_W'(1))
                r_state <= S_DONE;
        end else if (w_accept) begin
            r_shreg <= bus.pattern;
            r_len   <= w_len_clamped;
            r_cnt   <= '0;
            r_state <= (w_len_clamped == '0) ? S_DONE : S_SHIFT;
        end else begin
            r_state <= S_IDLE;
        end
    end

    assign bus.busy    = (r_state == S_SHIFT);
    assign bus.w_valid = (r_state == S_SHIFT);
    assign bus.w       = (r_state == S_SHIFT) && r_shreg[0];
    assign bus.done    = (r_state == S_DONE);

`ifdef W_SEQ_DRV_PREDICT_EN
    w_seq_model u_model (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_w       (bus.w),
        .i_w_valid (bus.w_valid),
        .i_clear   (w_accept),
        .o_z_exp   (bus.z_exp),
        .o_hit_cnt (bus.hit_cnt)
    );
`else
    assign bus.z_exp   = 1'b0;
    assign bus.hit_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_w_seq_driver.sv
// Self-checking bench for w_seq_driver: directed scenarios plus randomized runs against
// a table-driven detector reference model.
module tb_w_seq_driver;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
`ifdef W_SEQ_DRV_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // reference detector: next-state tables indexed by state A..F = 0..5
    int   nxt1 [6] = '{1, 2, 4, 5, 4, 2};
    int   nxt0 [6] = '{0, 3, 3, 0, 3, 3};
    int   m_state = 0;
    int   m_hits  = 0;

    always #5 clk = ~clk;

    w_seq_driver_if #(.MAX_LEN(MAX_LEN)) bus ();

    w_seq_driver #(.MAX_LEN(MAX_LEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [12:0] observed();
        return {bus.busy, bus.w_valid, bus.w, bus.done, bus.z_exp, bus.hit_cnt};
    endfunction

    function automatic logic model_z();
        return PRED && (m_state >= 4);
    endfunction

    function automatic logic [7:0] model_hits();
        return PRED ? 8'(m_hits) : 8'd0;
    endfunction

    // Accepts one run at the next edge and checks every cycle through DONE.
    // ign_idx selects a busy cycle in which a stray start is issued.
    task automatic do_run(input int l_in, input logic [MAX_LEN-1:0] pat,
                          input int ign_idx, input string tag);
        int l;
        logic [12:0] exp_v;
        logic [12:0] obs_v;
        l = (l_in > MAX_LEN) ? MAX_LEN : l_in;
        bus.start   = 1'b1;
        bus.len     = LEN_W'(l_in);
        bus.pattern = pat;
        @(posedge clk);
        m_hits = 0;
        for (int i = 0; i < l; i++) begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.len     = LEN_W'($urandom);
            bus.pattern = MAX_LEN'($urandom);
            obs_v = observed();
            exp_v = {1'b1, 1'b1, pat[i], 1'b0, model_z(), model_hits()};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL %s bit cyc%0d got=%b exp=%b", tag, i + 1, obs_v, exp_v);
            end
            m_state = pat[i] ? nxt1[m_state] : nxt0[m_state];
            if (m_state >= 4 && m_hits < 255) m_hits++;
            if (i == ign_idx) bus.start = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        bus.start = 1'b0;
        obs_v = observed();
        exp_v = {1'b0, 1'b0, 1'b0, 1'b1, model_z(), model_hits()};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL %s done cyc%0d got=%b exp=%b", tag, l + 1, obs_v, exp_v);
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        logic [12:0] exp_v;
        logic [12:0] obs_v;
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_v = observed();
            exp_v = {4'b0000, model_z(), model_hits()};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL %s idle got=%b exp=%b", tag, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset(input int n);
        logic [12:0] obs_v;
        bus.start = 1'b0;
        reset_n   = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_v = observed();
            checks++;
            if (obs_v !== 13'd0) begin
                errors++;
                $display("FAIL reset got=%b exp=%b", obs_v, 13'd0);
            end
        end
        m_state = 0;
        m_hits  = 0;
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        test_reset(2);
        do_run(4, MAX_LEN'(4'b0111), -1, "pat0111");
        checks++;
        if (bus.hit_cnt !== (PRED ? 8'd1 : 8'd0)) begin
            errors++;
            $display("FAIL pat0111_hits got=%0d exp=%0d", bus.hit_cnt, PRED ? 1 : 0);
        end
        idle_cycles(2, "basic");
    endtask

    task automatic test_path_f();
        test_reset(2);
        do_run(4, MAX_LEN'(4'b1011), -1, "pat1011");
        idle_cycles(1, "path_f");
    endtask

    task automatic test_len_bounds();
        do_run(0, MAX_LEN'($urandom), -1, "len0");
        idle_cycles(1, "len0");
        do_run(20, MAX_LEN'($urandom), -1, "len20");
        idle_cycles(1, "len20");
        do_run(MAX_LEN, MAX_LEN'($urandom), -1, "lenmax");
        do_run(1, MAX_LEN'(1), -1, "len1");
    endtask

    task automatic test_back_to_back();
        do_run(3, MAX_LEN'(3'b111), -1, "b2b_a");
        do_run(3, MAX_LEN'(3'b111), -1, "b2b_b");
        checks++;
        if (bus.hit_cnt !== (PRED ? 8'd3 : 8'd0)) begin
            errors++;
            $display("FAIL b2b_hits got=%0d exp=%0d", bus.hit_cnt, PRED ? 3 : 0);
        end
        idle_cycles(1, "b2b");
    endtask

    task automatic test_ignore_and_abort();
        logic [MAX_LEN-1:0] pat;
        logic [12:0] exp_v;
        logic [12:0] obs_v;
        do_run(8, MAX_LEN'($urandom), 1, "ignore");
        pat = MAX_LEN'($urandom);
        bus.start   = 1'b1;
        bus.len     = LEN_W'(8);
        bus.pattern = pat;
        @(posedge clk);
        m_hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            obs_v = observed();
            exp_v = {1'b1, 1'b1, pat[i], 1'b0, model_z(), model_hits()};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL abort_run cyc%0d got=%b exp=%b", i + 1, obs_v, exp_v);
            end
            m_state = pat[i] ? nxt1[m_state] : nxt0[m_state];
            if (m_state >= 4 && m_hits < 255) m_hits++;
        end
        test_reset(2);
        do_run(4, MAX_LEN'(4'b0111), -1, "post_abort");
        idle_cycles(1, "post_abort");
    endtask

    task automatic test_random(input int n);
        int l;
        for (int k = 0; k < n; k++) begin
            l = $urandom_range(0, 20);
            do_run(l, MAX_LEN'($urandom), $urandom_range(0, l + 3), "rand");
            idle_cycles($urandom_range(0, 2), "rand");
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.len     = '0;
        bus.pattern = '0;
        test_reset(3);
        test_basic();
        test_path_f();
        test_len_bounds();
        test_back_to_back();
        test_ignore_and_abort();
        test_random(40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
